// File: rtl/ddr3_rd_data_checker_if.sv
// P3 user read port of the MCB (first-word-fall-through read FIFO).
// master: the consumer that pops words; slave: the FIFO side.
interface ddr3_rd_data_checker_if #(
    parameter int DATA_W = 32
);
    logic              p3_rd_empty;
    logic [DATA_W-1:0] p3_rd_data;
    logic              p3_rd_overflow;
    logic              p3_rd_en;

    modport master (
        output p3_rd_en,
        input  p3_rd_empty,
        input  p3_rd_data,
        input  p3_rd_overflow
    );

    modport slave (
        input  p3_rd_en,
        output p3_rd_empty,
        output p3_rd_data,
        output p3_rd_overflow
    );
endinterface

// File: rtl/ddr3_rd_data_checker.sv
// ddr3_rd_data_checker: drains MCB read port P3 and compares every word with
// the pattern the write path stored. Counts mismatches, captures the first one.
// Optional macro RD_CHK_LFSR_EN: expected sequence is a 32-bit Galois LFSR
// (x^32+x^22+x^2+x+1) instead of an incrementing count.
module ddr3_rd_data_checker #(
    parameter int                DATA_W      = 32,
    parameter int                CNT_W       = 16,
    parameter int                TOTAL_WORDS = 256,
    parameter logic [DATA_W-1:0] SEED        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    ddr3_rd_data_checker_if.master p3,
    output logic                  chk_busy,
    output logic                  chk_done,
    output logic                  chk_pass,
    output logic                  ovf_seen,
    output logic [CNT_W-1:0]      word_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      first_err_idx,
    output logic [DATA_W-1:0]     first_err_data,
    output logic [DATA_W-1:0]     first_err_exp
);

    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(TOTAL_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_WORDS - 1);

`ifdef RD_CHK_LFSR_EN
    localparam logic [DATA_W-1:0] TAPS     = DATA_W'(32'h8020_0003);
    // An all-zero LFSR state would lock up, so a zero seed starts at 1.
    localparam logic [DATA_W-1:0] GEN_INIT = (SEED == '0) ? DATA_W'(1) : SEED;

    function automatic logic [DATA_W-1:0] gen_next(input logic [DATA_W-1:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : '0);
    endfunction
`else
    localparam logic [DATA_W-1:0] GEN_INIT = SEED;

    function automatic logic [DATA_W-1:0] gen_next(input logic [DATA_W-1:0] x);
        return x + DATA_W'(1);
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] exp_gen;
    logic              cmp_vld;
    logic [DATA_W-1:0] cmp_data;
    logic [DATA_W-1:0] cmp_exp;
    logic [CNT_W-1:0]  cmp_idx;
    logic              pop;
    logic              mism;
    logic              last_retire;

    assign pop         = (state == RUN) && !p3.p3_rd_empty && (word_cnt < TOTAL);
    assign p3.p3_rd_en = pop;
    assign mism        = cmp_vld && (cmp_data != cmp_exp);
    assign last_retire = cmp_vld && (cmp_idx == LAST_IDX);

    // Run FSM, pop/generator stage and one-cycle compare stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            exp_gen        <= GEN_INIT;
            cmp_vld        <= 1'b0;
            cmp_data       <= '0;
            cmp_exp        <= '0;
            cmp_idx        <= '0;
            chk_busy       <= 1'b0;
            chk_done       <= 1'b0;
            chk_pass       <= 1'b0;
            ovf_seen       <= 1'b0;
            word_cnt       <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
        end else begin
            cmp_vld <= pop;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        exp_gen        <= GEN_INIT;
                        chk_busy       <= 1'b1;
                        chk_done       <= 1'b0;
                        chk_pass       <= 1'b0;
                        ovf_seen       <= 1'b0;
                        word_cnt       <= '0;
                        err_cnt        <= '0;
                        first_err_idx  <= '0;
                        first_err_data <= '0;
                        first_err_exp  <= '0;
                    end
                end
                RUN: begin
                    if (pop) begin
                        word_cnt <= word_cnt + 1'b1;
                        exp_gen  <= gen_next(exp_gen);
                        cmp_data <= p3.p3_rd_data;
                        cmp_exp  <= exp_gen;
                        cmp_idx  <= word_cnt;
                    end
                    if (mism) begin
                        if (!(&err_cnt))
                            err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) begin
                            first_err_idx  <= cmp_idx;
                            first_err_data <= cmp_data;
                            first_err_exp  <= cmp_exp;
                        end
                    end
                    if (p3.p3_rd_overflow)
                        ovf_seen <= 1'b1;
                    // The final compare is folded into the pass verdict here,
                    // since err_cnt/ovf_seen update on this same edge.
                    if (last_retire) begin
                        state    <= DONE;
                        chk_busy <= 1'b0;
                        chk_done <= 1'b1;
                        chk_pass <= !mism && (err_cnt == '0) && !ovf_seen && !p3.p3_rd_overflow;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_rd_data_checker.sv
// Directed bench for ddr3_rd_data_checker: a table of whole-run scenarios driven
// by a small FWFT FIFO model, plus hand sequences for latency, reset and stalls.
module tb_ddr3_rd_data_checker;

    localparam logic [31:0] SEED1 = 32'hFFFF_FFFE;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;

    logic        busy[2], done[2], pass[2], ovf[2], en[2];
    logic [15:0] wc[2], ec[2], fidx[2];
    logic [31:0] fdata[2], fexp[2];

    ddr3_rd_data_checker_if #(.DATA_W(32)) bus0 ();
    ddr3_rd_data_checker_if #(.DATA_W(32)) bus1 ();

    assign en[0] = bus0.p3_rd_en;
    assign en[1] = bus1.p3_rd_en;

    ddr3_rd_data_checker #(.DATA_W(32), .CNT_W(16), .TOTAL_WORDS(256), .SEED(32'h0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .p3(bus0.master),
        .chk_busy(busy[0]), .chk_done(done[0]), .chk_pass(pass[0]), .ovf_seen(ovf[0]),
        .word_cnt(wc[0]), .err_cnt(ec[0]), .first_err_idx(fidx[0]),
        .first_err_data(fdata[0]), .first_err_exp(fexp[0])
    );

    ddr3_rd_data_checker #(.DATA_W(32), .CNT_W(16), .TOTAL_WORDS(256), .SEED(SEED1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .p3(bus1.master),
        .chk_busy(busy[1]), .chk_done(done[1]), .chk_pass(pass[1]), .ovf_seen(ovf[1]),
        .word_cnt(wc[1]), .err_cnt(ec[1]), .first_err_idx(fidx[1]),
        .first_err_data(fdata[1]), .first_err_exp(fexp[1])
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference pattern written by the write path.
    function automatic logic [31:0] pat(input logic [31:0] seed, input int i);
`ifdef RD_CHK_LFSR_EN
        logic [31:0] x;
        x = (seed == 32'h0) ? 32'h1 : seed;
        for (int k = 0; k < i; k++)
            x = {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
        return x;
`else
        return seed + 32'(i);
`endif
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v; else start1 = v;
    endtask

    task automatic drive(input logic e, input logic [31:0] d0, input logic [31:0] d1,
                         input logic o0, input logic o1);
        bus0.p3_rd_empty = e;   bus1.p3_rd_empty = e;
        bus0.p3_rd_data  = d0;  bus1.p3_rd_data  = d1;
        bus0.p3_rd_overflow = o0;
        bus1.p3_rd_overflow = o1;
    endtask

    task automatic chk_zero(input string nm, input int sel);
        chk({nm, "_flags"}, {60'h0, busy[sel], done[sel], pass[sel], ovf[sel]}, 64'h0);
        chk({nm, "_cnts"}, {16'h0, wc[sel], ec[sel], fidx[sel]}, 64'h0);
        chk({nm, "_fdat"}, {fdata[sel], fexp[sel]}, 64'h0);
        chk({nm, "_en"}, {63'h0, en[sel]}, 64'h0);
    endtask

    typedef struct {
        string       name;
        int          sel;
        int          corrupt_idx;
        logic [31:0] corrupt_val;
        bit          rand_empty;
        int          ovf_at;
        int          start_at;
        bit          start_last;
        int          exp_err;
        bit          exp_pass;
        bit          exp_ovf;
        int          exp_fidx;
        logic [31:0] exp_fdata;
        logic [31:0] exp_fexp;
    } vec_t;

    function automatic vec_t mk(input string name, input int sel, input int cidx,
                                input logic [31:0] cval, input bit re, input int ovf_at,
                                input int st_at, input bit st_last, input int e_err,
                                input bit e_pass, input bit e_ovf, input int e_fidx,
                                input logic [31:0] e_fdata, input logic [31:0] e_fexp);
        vec_t v;
        v.name = name; v.sel = sel; v.corrupt_idx = cidx; v.corrupt_val = cval;
        v.rand_empty = re; v.ovf_at = ovf_at; v.start_at = st_at; v.start_last = st_last;
        v.exp_err = e_err; v.exp_pass = e_pass; v.exp_ovf = e_ovf; v.exp_fidx = e_fidx;
        v.exp_fdata = e_fdata; v.exp_fexp = e_fexp;
        return v;
    endfunction

    // One full run against the FIFO model; entered and left just after a negedge.
    task automatic run_vec(input vec_t v);
        int ptr, cyc, viol;
        bit sflag, oflag, e, o, s;
        logic [31:0] d0, d1;
        int sel;
        sel = v.sel;
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        chk({v.name, "_start_clr"}, {47'h0, done[sel], busy[sel], wc[sel]}, {47'h0, 1'b0, 1'b1, 16'h0});
        ptr = 0; cyc = 0; viol = 0; sflag = 0; oflag = 0;
        while (!done[sel] && cyc < 5000) begin
            s = 0;
            if (v.start_at >= 0 && ptr == v.start_at && !sflag) begin s = 1; sflag = 1; end
            if (v.start_last && ptr == 256 && !sflag) begin s = 1; sflag = 1; end
            set_start(sel, s);
            e = (ptr >= 256) || (v.rand_empty && $urandom_range(1) == 1);
            o = (v.ovf_at >= 0 && ptr == v.ovf_at && !oflag);
            if (o) oflag = 1;
            d0 = pat(32'h0, ptr);
            d1 = pat(SEED1, ptr);
            if (ptr == v.corrupt_idx) begin d0 = v.corrupt_val; d1 = v.corrupt_val; end
            drive(e, d0, d1, (sel == 0) && o, (sel == 1) && o);
            #1;
            if (en[sel] && e) viol++;
            if (en[sel]) ptr++;
            @(negedge clk);
            cyc++;
        end
        set_start(sel, 1'b0);
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        chk({v.name, "_timeout"}, 64'(cyc < 5000), 64'h1);
        chk({v.name, "_en_while_empty"}, 64'(viol), 64'h0);
        chk({v.name, "_pops"}, 64'(ptr), 64'd256);
        chk({v.name, "_done_busy"}, {62'h0, done[sel], busy[sel]}, {62'h0, 2'b10});
        chk({v.name, "_word_cnt"}, 64'(wc[sel]), 64'd256);
        chk({v.name, "_err_cnt"}, 64'(ec[sel]), 64'(v.exp_err));
        chk({v.name, "_pass"}, 64'(pass[sel]), 64'(v.exp_pass));
        chk({v.name, "_ovf_seen"}, 64'(ovf[sel]), 64'(v.exp_ovf));
        chk({v.name, "_first_idx"}, 64'(fidx[sel]), 64'(v.exp_fidx));
        chk({v.name, "_first_data"}, 64'(fdata[sel]), 64'(v.exp_fdata));
        chk({v.name, "_first_exp"}, 64'(fexp[sel]), 64'(v.exp_fexp));
        @(negedge clk);
        chk({v.name, "_done_hold"}, {47'h0, done[sel], wc[sel]}, {47'h0, 1'b1, 16'd256});
    endtask

    vec_t tab[6];

    initial begin
        int ptr, cyc;
        tab[0] = mk("clean",      0, -1, 32'h0,         0, -1,  -1, 0, 0, 1, 0,  0, 32'h0,         32'h0);
        tab[1] = mk("corrupt17",  0, 17, 32'hDEAD_BEEF, 0, -1,  -1, 0, 1, 0, 0, 17, 32'hDEAD_BEEF, pat(32'h0, 17));
        tab[2] = mk("rand_empty", 0, -1, 32'h0,         1, -1, 120, 0, 0, 1, 0,  0, 32'h0,         32'h0);
        tab[3] = mk("seed_wrap",  1, -1, 32'h0,         0, -1,  -1, 0, 0, 1, 0,  0, 32'h0,         32'h0);
        tab[4] = mk("overflow50", 0, -1, 32'h0,         1, 50,  -1, 0, 0, 0, 1,  0, 32'h0,         32'h0);
        tab[5] = mk("start_last", 0, -1, 32'h0,         0, -1,  -1, 1, 0, 1, 0,  0, 32'h0,         32'h0);

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk_zero("reset0", 0);
        chk_zero("reset1", 1);
        rst = 1'b0;
        @(negedge clk);

        // Pop-to-compare latency: a bad word 0 shows in err_cnt one edge after the pop.
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drive(1'b0, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
        #1;
        chk("lat_en", 64'(en[0]), 64'h1);
        @(negedge clk);
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("lat_pop_edge", {32'h0, wc[0], ec[0]}, {32'h0, 16'd1, 16'd0});
        @(negedge clk);
        chk("lat_cmp_edge", {32'h0, ec[0], fidx[0]}, {32'h0, 16'd1, 16'd0});
        chk("lat_first", {fdata[0], fexp[0]}, {32'h0000_1234, pat(32'h0, 0)});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("lat_rst", 0);

        foreach (tab[i]) run_vec(tab[i]);

        // Empty FIFO in RUN: run waits, nothing moves.
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("stall_state", {46'h0, busy[0], done[0], en[0], ec[0]}, {46'h0, 3'b100, 16'h0});
        chk("stall_wc", 64'(wc[0]), 64'h0);

        // Reset after 100 pops aborts the run; a fresh run then completes cleanly.
        ptr = 0; cyc = 0;
        while (ptr < 100 && cyc < 1000) begin
            drive(1'b0, pat(32'h0, ptr), 32'h0, 1'b0, 1'b0);
            #1;
            if (en[0]) ptr++;
            if (ptr < 100) @(negedge clk);
            cyc++;
        end
        chk("abort_reach100", 64'(ptr), 64'd100);
        @(negedge clk);
        chk("abort_wc_before", 64'(wc[0]), 64'd100);
        rst = 1'b1;
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("abort_rst", 0);
        @(negedge clk);
        run_vec(tab[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
